// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block instruction cache sitting between the
// datapath fetch port and the memory controller instruction port. A hit is
// answered in the same cycle. A miss runs a single-word fill from memory.
// Also provides flush and hit/miss performance counters.
module icache_direct #(
   parameter int NSETS = 16,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             imemREN,
   input  logic [31:0]      imemaddr,
   output logic             ihit,
   output logic [31:0]      imemload,
   output logic             iREN,
   output logic [31:0]      iaddr,
   input  logic             iwait,
   input  logic [31:0]      iload,
   input  logic             flush,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   localparam int IDX_W = $clog2(NSETS);
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [NSETS-1:0]   valid_q;
   logic [TAG_W-1:0]   tag_q  [NSETS];
   logic [31:0]        data_q [NSETS];
   logic [29:0]        miss_word_q;
   logic               flush_pend_q;
   logic [CNT_W-1:0]   hit_count_q;
   logic [CNT_W-1:0]   miss_count_q;

   logic [IDX_W-1:0]   req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic [IDX_W-1:0]   fill_idx;
   logic [TAG_W-1:0]   fill_tag;
   logic               lookup_hit;
   logic               start_miss;
   logic               fill_done;
   logic               unused_addr_lsb;

   // Byte offset bits never select anything: fetches are whole words.
   assign unused_addr_lsb = ^imemaddr[1:0];

   assign req_idx    = imemaddr[IDX_W+1:2];
   assign req_tag    = imemaddr[31:IDX_W+2];
   assign fill_idx   = miss_word_q[IDX_W-1:0];
   assign fill_tag   = miss_word_q[29:IDX_W];
   assign lookup_hit = imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;

   // State register; reset abandons any in-flight fill.
   always_ff @(posedge CLK) begin
      if (nRST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state: a miss starts a fill, a fill ends when memory stops waiting.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_miss) state_d = FILL;
         FILL: if (!iwait)     state_d = IDLE;
         default:              state_d = IDLE;
      endcase
   end

   // Outputs and per-cycle events. A flush cycle in IDLE neither hits nor
   // starts a miss; the request is looked up again once the flush is done.
   always_comb begin
      ihit       = 1'b0;
      imemload   = 32'h0;
      iREN       = 1'b0;
      iaddr      = 32'h0;
      start_miss = 1'b0;
      fill_done  = 1'b0;
      case (state_q)
         IDLE: begin
            ihit       = lookup_hit & ~flush;
            imemload   = (lookup_hit & ~flush) ? data_q[req_idx] : 32'h0;
            start_miss = imemREN & ~lookup_hit & ~flush;
         end
         FILL: begin
            iREN      = 1'b1;
            iaddr     = {miss_word_q, 2'b00};
            fill_done = ~iwait;
         end
         default: ;
      endcase
   end

   // Miss address capture; held for the whole fill so iaddr stays stable.
   always_ff @(posedge CLK) begin
      if (start_miss) miss_word_q <= imemaddr[31:2];
   end

   // Line storage; a fill overwrites the frame unconditionally.
   always_ff @(posedge CLK) begin
      if (fill_done) begin
         data_q[fill_idx] <= iload;
         tag_q[fill_idx]  <= fill_tag;
      end
   end

   // Remember a flush that arrives mid-fill so the fill result is discarded.
   always_ff @(posedge CLK) begin
      if (nRST)                             flush_pend_q <= 1'b0;
      else if (state_q != FILL || fill_done) flush_pend_q <= 1'b0;
      else if (flush)                        flush_pend_q <= 1'b1;
   end

   // Valid bits: flush (now or pending at fill end) clears all, else a fill sets one.
   always_ff @(posedge CLK) begin
      if (nRST)                                 valid_q <= '0;
      else if (flush | (fill_done & flush_pend_q)) valid_q <= '0;
      else if (fill_done)                       valid_q[fill_idx] <= 1'b1;
   end

   // Performance counters, wrapping naturally at 2^CNT_W.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_q  + CNT_W'(ihit);
         miss_count_q <= miss_count_q + CNT_W'(start_miss);
      end
   end

endmodule

// File: tb/tb_icache_direct.sv
// Testbench for icache_direct: a delayed-response memory, a behavioural
// cache model (arrays of valid/tag/data plus hit/miss tallies) and one task
// per scenario, followed by a randomized access mix.
module tb_icache_direct;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        flush;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   bit          ref_valid [16];
   logic [25:0] ref_tag   [16];
   logic [31:0] ref_data  [16];
   logic [31:0] ref_hits;
   logic [31:0] ref_misses;

   // Memory responder controls
   int mem_waits = 0;
   int mem_cnt   = 0;

   icache_direct #(.NSETS(16), .CNT_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload), .flush(flush),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] memval(input logic [31:0] a);
      logic [31:0] w;
      w = {2'b00, a[31:2]};
      if (w == 32'h10) return 32'h8C010004;
      return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) ref_valid[i] = 0;
      ref_hits   = 0;
      ref_misses = 0;
   endfunction

   function automatic void model_flush();
      for (int i = 0; i < 16; i++) ref_valid[i] = 0;
   endfunction

   // Memory: holds iwait high for mem_waits cycles of a request, then returns data.
   always @(negedge CLK) begin
      if (iREN === 1'b1) begin
         if (mem_cnt < mem_waits) begin
            iwait = 1'b1;
            mem_cnt++;
         end else begin
            iwait = 1'b0;
            iload = memval(iaddr);
         end
      end else begin
         mem_cnt = 0;
         iwait   = 1'b1;
         iload   = 32'hDEADBEEF;
      end
   end

   // One fetch: hold the request until ihit, checking latency, memory traffic and data.
   task automatic do_access(input logic [31:0] addr, input int waits, input string name);
      int          idx;
      logic [25:0] tg;
      bit          exp_hit;
      bit          got;
      int          lat;
      int          rens;
      int          exp_lat;
      idx     = int'(addr[5:2]);
      tg      = addr[31:6];
      exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
      exp_lat = exp_hit ? 0 : waits + 2;
      mem_waits = waits;
      imemREN = 1'b1;
      imemaddr = addr;
      got = 0; lat = 0; rens = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge CLK);
         if (ihit === 1'b1) begin
            got = 1;
            lat = c;
            break;
         end
         if (iREN === 1'b1) begin
            rens++;
            compared++;
            if (iaddr !== {addr[31:2], 2'b00}) begin
               mismatched++;
               $display("FAIL %s iaddr: got %h expected %h", name, iaddr, {addr[31:2], 2'b00});
            end
         end
         @(posedge CLK); #1;
      end
      compared++;
      if (!got) begin
         mismatched++;
         $display("FAIL %s timeout: no ihit within 200 cycles, expected latency %0d", name, exp_lat);
      end else begin
         if (!exp_hit) begin
            ref_valid[idx] = 1;
            ref_tag[idx]   = tg;
            ref_data[idx]  = memval(addr);
            ref_misses++;
         end
         ref_hits++;
         compared++;
         if (lat != exp_lat) begin
            mismatched++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
         end
         compared++;
         if (rens != (exp_hit ? 0 : waits + 1)) begin
            mismatched++;
            $display("FAIL %s iREN cycles: got %0d expected %0d", name, rens, exp_hit ? 0 : waits + 1);
         end
         compared++;
         if (imemload !== ref_data[idx]) begin
            mismatched++;
            $display("FAIL %s imemload: got %h expected %h", name, imemload, ref_data[idx]);
         end
      end
      @(posedge CLK); #1;
      imemREN = 1'b0;
   endtask

   task automatic test_reset();
      nRST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0; flush = 1'b0;
      repeat (2) @(posedge CLK);
      #1 nRST = 1'b0;
      model_reset();
      @(negedge CLK);
      compared++;
      if ({ihit, iREN} !== 2'b00) begin
         mismatched++;
         $display("FAIL reset ihit/iREN: got %b%b expected 00", ihit, iREN);
      end
      compared++;
      if (imemload !== 32'h0 || iaddr !== 32'h0) begin
         mismatched++;
         $display("FAIL reset imemload/iaddr: got %h/%h expected 0/0", imemload, iaddr);
      end
      compared++;
      if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
         mismatched++;
         $display("FAIL reset counters: got %0d/%0d expected 0/0", hit_count, miss_count);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_cold_miss();
      do_access(32'h40, 2, "cold_miss");
      compared++;
      if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
         mismatched++;
         $display("FAIL cold_miss counters: got hit %0d miss %0d expected 1/1", hit_count, miss_count);
      end
   endtask

   task automatic test_repeat_hit();
      for (int i = 0; i < 4; i++) do_access(32'h40, 3, "repeat_hit");
      compared++;
      if (hit_count !== ref_hits || miss_count !== ref_misses) begin
         mismatched++;
         $display("FAIL repeat_hit counters: got %0d/%0d expected %0d/%0d", hit_count, miss_count, ref_hits, ref_misses);
      end
   endtask

   task automatic test_conflict();
      do_access(32'h80, 1, "conflict_80");
      do_access(32'h40, 1, "conflict_40");
      compared++;
      if (miss_count !== 32'd3 || hit_count !== ref_hits) begin
         mismatched++;
         $display("FAIL conflict counters: got miss %0d hit %0d expected 3/%0d", miss_count, hit_count, ref_hits);
      end
   endtask

   task automatic test_low_bits();
      do_access(32'h44, 0, "lowbits_fill");
      do_access(32'h47, 2, "lowbits_47");
      do_access(32'h45, 2, "lowbits_45");
   endtask

   task automatic test_flush_idle();
      do_access(32'h40, 0, "flush_prefill");
      imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b1;
      @(negedge CLK);
      compared++;
      if ({ihit, iREN} !== 2'b00) begin
         mismatched++;
         $display("FAIL flush_idle ihit/iREN: got %b%b expected 00", ihit, iREN);
      end
      @(posedge CLK); #1;
      flush = 1'b0; imemREN = 1'b0;
      model_flush();
      do_access(32'h40, 1, "flush_idle_refetch");
      compared++;
      if (hit_count !== ref_hits || miss_count !== ref_misses) begin
         mismatched++;
         $display("FAIL flush_idle counters: got %0d/%0d expected %0d/%0d", hit_count, miss_count, ref_hits, ref_misses);
      end
   endtask

   task automatic test_flush_fill();
      bit done;
      mem_waits = 3;
      imemREN = 1'b1; imemaddr = 32'h48;
      @(negedge CLK);
      compared++;
      if (ihit !== 1'b0) begin
         mismatched++;
         $display("FAIL flush_fill first ihit: got %b expected 0", ihit);
      end
      @(posedge CLK); #1;
      flush = 1'b1;
      @(posedge CLK); #1;
      flush = 1'b0;
      imemREN = 1'b0;
      imemaddr = 32'h12345678;
      ref_misses++;
      model_flush();
      done = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (iREN !== 1'b1) begin
            done = 1;
            break;
         end
         compared++;
         if (iaddr !== 32'h48) begin
            mismatched++;
            $display("FAIL flush_fill iaddr hold: got %h expected 00000048", iaddr);
         end
      end
      compared++;
      if (!done) begin
         mismatched++;
         $display("FAIL flush_fill timeout: iREN still %b after 20 cycles, expected 0", iREN);
      end
      @(posedge CLK); #1;
      do_access(32'h48, 0, "flush_fill_refetch");
      compared++;
      if (hit_count !== ref_hits || miss_count !== ref_misses) begin
         mismatched++;
         $display("FAIL flush_fill counters: got %0d/%0d expected %0d/%0d", hit_count, miss_count, ref_hits, ref_misses);
      end
   endtask

   task automatic test_reset_mid_fill();
      do_access(32'h4C, 0, "rst_prefill");
      do_access(32'h4C, 0, "rst_prehit");
      mem_waits = 1000;
      imemREN = 1'b1; imemaddr = 32'h50;
      @(posedge CLK); #1;
      @(negedge CLK);
      compared++;
      if (iREN !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_mid_fill in-fill iREN: got %b expected 1", iREN);
      end
      @(posedge CLK); #1;
      nRST = 1'b1; imemREN = 1'b0;
      @(posedge CLK); #1;
      nRST = 1'b0;
      model_reset();
      @(negedge CLK);
      compared++;
      if (iREN !== 1'b0 || ihit !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_mid_fill iREN/ihit: got %b/%b expected 0/0", iREN, ihit);
      end
      compared++;
      if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
         mismatched++;
         $display("FAIL reset_mid_fill counters: got %0d/%0d expected 0/0", hit_count, miss_count);
      end
      @(posedge CLK); #1;
      do_access(32'h4C, 1, "reset_mid_fill_refetch");
   endtask

   task automatic test_random();
      logic [31:0] a;
      int          op;
      for (int i = 0; i < 120; i++) begin
         op = int'($urandom_range(0, 11));
         if (op == 0) begin
            flush = 1'b1;
            @(posedge CLK); #1;
            flush = 1'b0;
            model_flush();
         end else if (op == 1) begin
            @(posedge CLK); #1;
         end else begin
            if (op == 2) a = $urandom;
            else a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            do_access(a, int'($urandom_range(0, 3)), "random");
         end
      end
      compared++;
      if (hit_count !== ref_hits || miss_count !== ref_misses) begin
         mismatched++;
         $display("FAIL random counters: got %0d/%0d expected %0d/%0d", hit_count, miss_count, ref_hits, ref_misses);
      end
   endtask

   initial begin
      iwait = 1'b1;
      iload = 32'h0;
      test_reset();
      test_cold_miss();
      test_repeat_hit();
      test_conflict();
      test_low_bits();
      test_flush_idle();
      test_flush_fill();
      test_reset_mid_fill();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-block instruction cache between the datapath's instruction fetch port (imemREN/imemaddr/ihit/imemload) and the memory controller's instruction port (iREN/iaddr/iwait/iload).
- Hits return in the same cycle; misses run a single-word fill from memory, then the access hits.
- Includes a flush input and hit/miss performance counters.

Parameters:
- NSETS, 16, number of frames; power of two, at least 2. IDX_W = log2(NSETS).
- CNT_W, 32, width of each performance counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  synchronous reset, active-high: reset when sampled 1 at a CLK rising edge.
- imemREN  in  1  datapath instruction read request.
- imemaddr  in  32  datapath fetch address (byte address).
- ihit  out  1  request satisfied this cycle.
- imemload  out  32  instruction word; valid only when ihit=1.
- iREN  out  1  memory read request.
- iaddr  out  32  memory read address, word aligned.
- iwait  in  1  memory busy; iload is valid in the cycle where iREN=1 and iwait=0.
- iload  in  32  memory read data.
- flush  in  1  invalidate all frames.
- hit_count  out  CNT_W  number of hits since reset.
- miss_count  out  CNT_W  number of misses since reset.

Behaviour:
- Address split: imemaddr[1:0] is ignored; index = imemaddr[IDX_W+1:2]; tag = imemaddr[31:IDX_W+2].
- Storage per frame: valid bit, tag, 32-bit data. No per-frame data reset is required; only valid bits are reset.
- FSM has two states, IDLE and FILL.
- IDLE:
  - ihit = imemREN & valid[index] & (tag_store[index]==tag). This is combinational, so a hit has zero cycles of latency.
  - imemload = data_store[index] when ihit, else 32'h0.
  - iREN = 0.
  - A miss (imemREN & !hit) latches miss_addr = {imemaddr[31:2],2'b00}, increments miss_count and moves to FILL at the next edge.
  - A hit increments hit_count, once per cycle in which ihit=1.
- FILL:
  - iREN = 1 and iaddr = miss_addr.
  - ihit = 0 and imemload = 0.
  - When iwait=0: write data_store/tag_store/valid of the miss_addr index with iload and the miss_addr tag, then return to IDLE.
  - The stalled request therefore hits in the first IDLE cycle after the fill, giving a miss latency of (memory wait cycles + 2) cycles from request to ihit.
  - When iwait=1: stay in FILL and hold iaddr stable.
- Request drop: if imemREN deasserts or imemaddr changes during FILL, the fill still completes, because a memory transaction cannot be aborted. The filled line is written and no extra hit is counted.
- flush:
  - In IDLE, flush clears all valid bits at the edge, and ihit is forced to 0 in that cycle (no hit counted).
  - In FILL, flush is remembered. The fill completes its handshake, but its write leaves the line invalid, and all valid bits are cleared on that edge.
- Index collision: a fill overwrites the frame unconditionally. There is no dirty state, since instruction memory is read-only.
- Counters wrap modulo 2^CNT_W.
- Reset (nRST=1 at an edge), from any state including mid-FILL:
  - state <= IDLE; all valid <= 0; hit_count and miss_count <= 0.
  - A pending memory request is dropped; iREN reads 0 the cycle after reset.
- Outputs during and after reset: ihit=0, imemload=0, iREN=0, iaddr=0 (iaddr drives 0 in IDLE).
- No combinational path from iload/iwait to ihit.

Test Plan:
- Cold miss: reset, imemREN=1 with imemaddr=0x00000040, and memory returns 0x8C010004 after 2 iwait cycles. Required: iREN=1 with iaddr=0x40 for 3 cycles; then ihit=1 and imemload=0x8C010004 in the following cycle; miss_count=1, hit_count=1.
- Repeated hit: re-read 0x40 for 4 consecutive cycles. Required: ihit=1 every cycle, iREN=0, hit_count increases by 4.
- Conflict: with NSETS=16, fill 0x40 and then access 0x80 (same index 0, different tag). Required: miss and fill of 0x80; a subsequent access to 0x40 misses again (miss_count=3).
- Low bits ignored: after filling 0x44, access 0x47. Required: ihit=1 with the same data and no memory request.
- Flush: fill 0x40, then pulse flush with imemREN=1 at 0x40. Required: ihit=0 in that cycle and a miss next cycle. Flush asserted during FILL of 0x48 must leave 0x48 invalid after the fill.
- Reset mid-fill: assert nRST while in FILL with iwait=1. Required: iREN=0 the next cycle, counters=0, and a prior hit address now misses.
